// File: rtl/expr_sig_compactor.sv
// MISR signature compactor for 90-bit expression results, with a pass/fail compare at end of run.
// Optional stall watchdog enabled by defining EXPR_SIG_STALL_CHECK_EN.
module expr_sig_compactor #(
  parameter logic [31:0] SEED  = 32'hFFFF_FFFF,
  parameter logic [31:0] POLY  = 32'h04C1_1DB7,
  parameter int          CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic [31:0]      golden,
  input  logic             in_valid,
  input  logic [89:0]      in_y,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [31:0]      sig,
  output logic [CNT_W-1:0] vec_cnt,
  output logic             timeout
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [31:0]      sig_q, sig_d;
  logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0] num_vec_q, num_vec_d;
  logic [31:0]      golden_q, golden_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;
  logic             start_ok;

  function automatic logic [31:0] fold(input logic [89:0] y);
    fold = y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]};
  endfunction

  function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [31:0] f);
    misr_step = {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ f;
  endfunction

`ifdef EXPR_SIG_STALL_CHECK_EN
  localparam logic [9:0] IDLE_MAX = 10'd1023;
  logic [9:0] idle_q, idle_d;
  logic       timeout_q, timeout_d;
`endif

  assign accept   = in_valid && (state_q == S_ACCUM);
  assign start_ok = start && (state_q != S_ACCUM);
  assign cnt_inc  = vec_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

  always_comb begin
    state_d   = state_q;
    sig_d     = sig_q;
    vec_cnt_d = vec_cnt_q;
    num_vec_d = num_vec_q;
    golden_d  = golden_q;
`ifdef EXPR_SIG_STALL_CHECK_EN
    idle_d    = idle_q;
    timeout_d = timeout_q;
`endif
    if (start_ok) begin
      sig_d     = SEED;
      vec_cnt_d = '0;
      num_vec_d = num_vec;
      golden_d  = golden;
      state_d   = (num_vec == '0) ? S_DONE : S_ACCUM;
`ifdef EXPR_SIG_STALL_CHECK_EN
      idle_d    = '0;
      timeout_d = 1'b0;
`endif
    end else if (state_q == S_ACCUM) begin
      if (accept) begin
        sig_d     = misr_step(sig_q, fold(in_y));
        vec_cnt_d = cnt_inc;
        if (cnt_inc == num_vec_q) state_d = S_DONE;
`ifdef EXPR_SIG_STALL_CHECK_EN
        idle_d    = '0;
      end else if (idle_q == IDLE_MAX) begin
        // Upstream has gone silent: abandon the run with a failing result.
        state_d   = S_DONE;
        timeout_d = 1'b1;
      end else begin
        idle_d    = idle_q + 10'd1;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      sig_q     <= SEED;
      vec_cnt_q <= '0;
`ifdef EXPR_SIG_STALL_CHECK_EN
      idle_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sig_q     <= sig_d;
      vec_cnt_q <= vec_cnt_d;
`ifdef EXPR_SIG_STALL_CHECK_EN
      idle_q    <= idle_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  // Run parameters are only meaningful after a start, so they carry no reset.
  always_ff @(posedge clk) begin
    num_vec_q <= num_vec_d;
    golden_q  <= golden_d;
  end

`ifdef EXPR_SIG_STALL_CHECK_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign in_ready = (state_q == S_ACCUM);
  assign busy     = (state_q == S_ACCUM);
  assign done     = (state_q == S_DONE);
  assign pass     = done && (sig_q == golden_q) && !timeout;
  assign sig      = sig_q;
  assign vec_cnt  = vec_cnt_q;

endmodule
